cdb_arbiter: RTL

Common-data-bus arbiter between the execution units and the ROB/RS/LSB broadcast ports. It buffers completed results from the ALU (RS side) and the LSB in per-source FIFOs and grants one result per cycle onto a single registered broadcast bus. Grants alternate round-robin between the two sources. The bus is flushed with the ROB's wrong-prediction `clear_up`. Because only one source drives the bus per cycle, consumers never see two broadcasts targeting the ROB in the same cycle.

---
 rtl/cdb_arbiter_if.sv | 36 +++
 rtl/cdb_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Result handshakes from the ALU and LSB plus the registered common-data-bus broadcast.
// The arbiter connects through the slave modport; producers/consumers use master.
interface cdb_arbiter_if #(
    parameter int ROB_BIT = 4
);
    logic               alu_valid;
    logic [ROB_BIT-1:0] alu_rob_entry;
    logic [31:0]        alu_value;
    logic               alu_ready;

    logic               lsb_valid;
    logic [ROB_BIT-1:0] lsb_rob_entry;
    logic [31:0]        lsb_value;
    logic               lsb_ready;

    logic               cdb_valid;
    logic [ROB_BIT-1:0] cdb_rob_entry;
    logic [31:0]        cdb_value;
    logic               cdb_src;

    modport master (
        output alu_valid, alu_rob_entry, alu_value,
        input  alu_ready,
        output lsb_valid, lsb_rob_entry, lsb_value,
        input  lsb_ready,
        input  cdb_valid, cdb_rob_entry, cdb_value, cdb_src
    );

    modport slave (
        input  alu_valid, alu_rob_entry, alu_value,
        output alu_ready,
        input  lsb_valid, lsb_rob_entry, lsb_value,
        output lsb_ready,
        output cdb_valid, cdb_rob_entry, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result FIFOs (ALU, LSB) drained round-robin onto one
// registered broadcast bus; flushed by clear_up, frozen while rdy_in is low.
module cdb_arbiter #(
    parameter int ROB_BIT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear_up,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ROB_BIT-1:0] rob_entry;
        logic [31:0]        value;
    } result_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    result_t          mem_q      [2][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q   [2];
    logic [PTR_W-1:0] wr_ptr_d   [2];
    logic [PTR_W-1:0] rd_ptr_q   [2];
    logic [PTR_W-1:0] rd_ptr_d   [2];
    logic [CNT_W-1:0] count_q    [2];
    logic [CNT_W-1:0] count_d    [2];
    src_e             last_grant_q, last_grant_d;
    logic             cdb_valid_q, cdb_valid_d;
    result_t          cdb_data_q, cdb_data_d;
    src_e             cdb_src_q, cdb_src_d;

    logic             in_valid   [2];
    result_t          in_data    [2];
    logic             ready      [2];
    logic             push       [2];
    logic             pop        [2];
    logic             nonempty   [2];
    logic             grant_any;
    src_e             grant_src;
    logic             advance;

    assign in_valid[0] = bus.alu_valid;
    assign in_valid[1] = bus.lsb_valid;
    assign in_data[0]  = '{rob_entry: bus.alu_rob_entry, value: bus.alu_value};
    assign in_data[1]  = '{rob_entry: bus.lsb_rob_entry, value: bus.lsb_value};

    // Ready looks at the registered count only, so a same-cycle pop never opens a slot.
    assign advance = rdy_in && !clear_up;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (count_q[s] != '0);
            ready[s]    = rdy_in && !rst_in && !clear_up &&
                          (count_q[s] != CNT_W'(FIFO_DEPTH));
            push[s]     = in_valid[s] && ready[s];
        end

        grant_any = nonempty[0] || nonempty[1];
        if (nonempty[0] && nonempty[1]) begin
            grant_src = (last_grant_q == SRC_ALU) ? SRC_LSB : SRC_ALU;
        end else if (nonempty[0]) begin
            grant_src = SRC_ALU;
        end else begin
            grant_src = SRC_LSB;
        end

        pop[0] = advance && grant_any && (grant_src == SRC_ALU);
        pop[1] = advance && grant_any && (grant_src == SRC_LSB);
    end

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_data_d   = cdb_data_q;
        cdb_src_d    = cdb_src_q;

        if (rdy_in) begin
            if (clear_up) begin
                for (int s = 0; s < 2; s++) begin
                    wr_ptr_d[s] = '0;
                    rd_ptr_d[s] = '0;
                    count_d[s]  = '0;
                end
                last_grant_d = SRC_LSB;
                cdb_valid_d  = 1'b0;
                cdb_data_d   = '0;
                cdb_src_d    = SRC_ALU;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
                    if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
                    count_d[s] = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
                end
                cdb_valid_d = grant_any;
                cdb_data_d  = grant_any ? mem_q[grant_src][rd_ptr_q[grant_src]] : '0;
                cdb_src_d   = grant_any ? grant_src : SRC_ALU;
                if (grant_any) last_grant_d = grant_src;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and counts alone decide what is valid.
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) mem_q[s][wr_ptr_q[s]] <= in_data[s];
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            last_grant_q <= SRC_LSB;
            cdb_valid_q  <= 1'b0;
            cdb_data_q   <= '0;
            cdb_src_q    <= SRC_ALU;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign bus.alu_ready     = ready[0];
    assign bus.lsb_ready     = ready[1];
    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.cdb_rob_entry = cdb_data_q.rob_entry;
    assign bus.cdb_value     = cdb_data_q.value;
    assign bus.cdb_src       = cdb_src_q;
endmodule
